// File: rtl/refresh_arbiter.sv
// refresh_arbiter: arbitrates memory ownership between host accesses and owed refreshes
// Ports: clk, rst (async, active-high); refresh_tick (one refresh owed), req (host level request),
//        access_done (granted access complete); gnt (host owns memory), ref_cmd (one-cycle refresh
//        command), ref_busy (refresh in progress), pending[3:0] (owed refreshes), overflow (sticky
//        tick lost at saturation).
module refresh_arbiter #(
    parameter int MAX_PENDING = 8,
    parameter int T_RFC       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_tick,
    input  logic       req,
    input  logic       access_done,
    output logic       gnt,
    output logic       ref_cmd,
    output logic       ref_busy,
    output logic [3:0] pending,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, ACCESS, REF_CMD, REF_WAIT} state_t;
    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       urgent, dec;
    assign urgent   = pending >= 4'(MAX_PENDING);
    assign dec      = state == REF_CMD;
    assign gnt      = state == ACCESS;
    assign ref_cmd  = state == REF_CMD;
    assign ref_busy = state == REF_CMD || state == REF_WAIT;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = urgent ? REF_CMD : req ? ACCESS : (pending != 4'd0) ? REF_CMD : IDLE;
            ACCESS:   next_state = access_done ? IDLE : ACCESS;
            REF_CMD:  next_state = REF_WAIT;
            REF_WAIT: next_state = (wait_cnt == 8'd0) ? IDLE : REF_WAIT;
            default:  next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            pending  <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= dec ? 8'(T_RFC - 1) : (state == REF_WAIT && wait_cnt != 8'd0) ? wait_cnt - 8'd1 : wait_cnt;
            // A tick coinciding with the REF_CMD decrement cancels out and cannot overflow
            if (refresh_tick && !dec) begin
                if (pending < 4'(MAX_PENDING)) pending <= pending + 4'd1;
                else overflow <= 1'b1;
            end else if (!refresh_tick && dec) begin
                pending <= pending - 4'd1;
            end
        end
    end
endmodule

// File: doc/refresh_arbiter.md
REFRESH_ARBITER -- requirements
Module: refresh_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_PENDING, default 8, meaning the refresh backlog at which refresh becomes urgent; legal range 1..15.
REQ-002 The block SHALL have parameter T_RFC, default 8, meaning the number of REF_WAIT cycles after each refresh command; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port refresh_tick, input, 1, one-cycle pulse from the refresh interval timer: one refresh owed.
REQ-006 The block SHALL have port req, input, 1, host access request, level, held until granted.
REQ-007 The block SHALL have port access_done, input, 1, one-cycle pulse: granted access complete.
REQ-008 The block SHALL have port gnt, output, 1, host owns the memory.
REQ-009 The block SHALL have port ref_cmd, output, 1, one-cycle refresh command to the memory.
REQ-010 The block SHALL have port ref_busy, output, 1, refresh in progress.
REQ-011 The block SHALL have port pending, output, 4, count of owed refreshes.
REQ-012 The block SHALL have port overflow, output, 1, sticky error: tick lost at saturation.

Function
REQ-013 The block SHALL implement states IDLE, ACCESS, REF_CMD and REF_WAIT, and all outputs SHALL be registered or decoded from the registered state.
REQ-014 In IDLE, when pending >= MAX_PENDING, the next state SHALL be REF_CMD (urgent), regardless of req.
REQ-015 In IDLE, when REQ-014 does not apply and req=1, the next state SHALL be ACCESS.
REQ-016 In IDLE, when req=0 and pending>0, the next state SHALL be REF_CMD (opportunistic); otherwise the block SHALL stay in IDLE.
REQ-017 In ACCESS, gnt SHALL be 1; on access_done=1 the next state SHALL be IDLE, and gnt SHALL be 0 from the following cycle.
REQ-018 An access SHALL never be preempted; an urgent refresh SHALL wait for access_done.
REQ-019 In REF_CMD, ref_cmd and ref_busy SHALL be 1 for exactly one cycle, pending SHALL decrement by 1, and the next state SHALL be REF_WAIT.
REQ-020 In REF_WAIT, ref_busy SHALL stay 1 for exactly T_RFC cycles, after which the next state SHALL be IDLE.
REQ-021 In REF_WAIT, a single 8-bit down-counter loaded with T_RFC-1 on REF_CMD exit SHALL time the wait.
REQ-022 gnt and ref_busy SHALL never be 1 in the same cycle.
REQ-023 When refresh_tick=1 and pending<MAX_PENDING, pending SHALL increment by 1.
REQ-024 When refresh_tick=1 and pending=MAX_PENDING with no simultaneous decrement, pending SHALL hold and overflow SHALL set to 1 until reset.
REQ-025 When refresh_tick and a REF_CMD decrement coincide, pending SHALL be unchanged and overflow SHALL not be set.
REQ-026 A refresh_tick pulse SHALL be counted in every state; ticks SHALL never be dropped below saturation.
REQ-027 Grant latency SHALL be 1 cycle: req sampled 1 in IDLE at edge k (no urgent refresh) gives gnt=1 after edge k.
REQ-028 access_done outside ACCESS SHALL be ignored.
REQ-029 Back-to-back refreshes SHALL return through IDLE for one cycle between REF_WAIT and the next REF_CMD.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, gnt=0, ref_cmd=0, ref_busy=0, pending=0, overflow=0 and the wait counter to 0.
REQ-031 rst asserted mid-ACCESS or mid-REF_WAIT SHALL abort the operation with no further ref_cmd, and owed refreshes SHALL be discarded.
REQ-032 On the first edge after rst deasserts, the block SHALL evaluate from IDLE with pending=0.

Verification
REQ-033 The bench SHALL cover: req=1, pending=0 -> gnt=1 next cycle; access_done after 5 cycles -> gnt=0 next cycle, and no ref_cmd.
REQ-034 The bench SHALL cover: one refresh_tick, req=0 -> pending=1, then ref_cmd for one cycle, pending=0, and ref_busy high for 1+8 cycles, then IDLE.
REQ-035 The bench SHALL cover: req held continuously with 8 ticks during ACCESS -> after access_done, REF_CMD beats req; pending goes 8->7 and gnt stays 0 until ref_busy falls.
REQ-036 The bench SHALL cover: 9 ticks with the block held in ACCESS -> pending=8 and overflow=1; then a tick coincident with REF_CMD -> pending unchanged at 8->8 and no extra overflow.
REQ-037 The bench SHALL cover: rst pulsed at the 3rd cycle of REF_WAIT with pending=4 -> all outputs 0 within the reset cycle, and no ref_cmd after release.
REQ-038 The bench SHALL cover: with T_RFC=1, back-to-back refreshes with pending=2 -> ref_cmd pulses separated by exactly 2 cycles (REF_WAIT, IDLE).
